// File: rtl/riscv_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// riscv_hazard_scoreboard
//
// Purpose:
//   Producer-side scoreboard for the EX-stage operand forwarding network. Every
//   register write accepted at ID issue is tracked until it is committed to the
//   register file. A per-register countdown gives the number of cycles until
//   the result becomes forwardable. ID is stalled while a source operand is
//   still counting down, or while a younger write would overtake an older write
//   to the same register (WAW).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   issue_valid       ID instruction presented for issue this cycle
//   issue_reg_write   issuing instruction writes issue_rd
//   issue_rd          destination register of the issuing instruction
//   issue_lat         cycles until forwardable (0 is treated as 1)
//   id_rs1_addr/used  ID source operand 1 address / read enable
//   id_rs2_addr/used  ID source operand 2 address / read enable
//   wb_valid, wb_rd   register-file commit of wb_rd this cycle
//   stall             ID must hold; the issue is not accepted (combinational)
//   busy_mask         registered: bit r set while register r has a pending write
//   pending_count     registered: population count of busy_mask
//
// Optional build macro RISCV_SCOREBOARD_STATS_EN adds:
//   stall_cycles      32-bit wrapping count of cycles with stall=1
//   raw_stall         stall caused by a source operand (separates WAW-only stalls)
// -----------------------------------------------------------------------------
module riscv_hazard_scoreboard #(
   parameter int LAT_W    = 3,
   parameter int NUM_REGS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic                issue_reg_write,
   input  logic [4:0]          issue_rd,
   input  logic [LAT_W-1:0]    issue_lat,
   input  logic [4:0]          id_rs1_addr,
   input  logic                id_rs1_used,
   input  logic [4:0]          id_rs2_addr,
   input  logic                id_rs2_used,
   input  logic                wb_valid,
   input  logic [4:0]          wb_rd,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic [5:0]          pending_count
`ifdef RISCV_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]         stall_cycles,
   output logic                raw_stall
`endif
);

   logic [NUM_REGS-1:0] r_busy;
   logic [LAT_W-1:0]    r_cnt [NUM_REGS];
   logic [5:0]          r_pending;

   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [LAT_W-1:0]    w_cnt_nxt [NUM_REGS];
   logic [5:0]          w_pop;
   logic [LAT_W-1:0]    w_eff_lat;
   logic                w_raw1;
   logic                w_raw2;
   logic                w_waw;
   logic                w_stall;
   logic                w_acc;

   // Hazard detection. A busy register whose countdown has reached 0 is already
   // on the forwarding network, so it does not stall a reader.
   // NOTE: every always_comb output gets a value on every path (here by direct
   // assignment, below by a default first) so no latch is inferred.
   always_comb begin
      w_eff_lat = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
      w_raw1    = id_rs1_used && (id_rs1_addr != 5'd0) && r_busy[id_rs1_addr]
                  && (r_cnt[id_rs1_addr] != '0);
      w_raw2    = id_rs2_used && (id_rs2_addr != 5'd0) && r_busy[id_rs2_addr]
                  && (r_cnt[id_rs2_addr] != '0);
      // A younger write must not land before an older one still in flight.
      w_waw     = issue_reg_write && (issue_rd != 5'd0) && r_busy[issue_rd]
                  && (r_cnt[issue_rd] >= w_eff_lat);
      w_stall   = issue_valid && (w_raw1 || w_raw2 || w_waw);
      w_acc     = issue_valid && !w_stall && issue_reg_write && (issue_rd != 5'd0);
   end

   // Next state per register: accept beats commit, commit beats countdown.
   // The accept-over-commit priority covers an older write retiring in the same
   // cycle that a newer write to the same register issues.
   always_comb begin
      w_busy_nxt = '0;
      w_pop      = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_cnt_nxt[r] = '0;
      end
      for (int r = 1; r < NUM_REGS; r++) begin
         if (w_acc && (issue_rd == 5'(r))) begin
            w_busy_nxt[r] = 1'b1;
            w_cnt_nxt[r]  = w_eff_lat;
         end else if (wb_valid && (wb_rd == 5'(r))) begin
            w_busy_nxt[r] = 1'b0;
            w_cnt_nxt[r]  = '0;
         end else begin
            w_busy_nxt[r] = r_busy[r];
            w_cnt_nxt[r]  = (r_busy[r] && (r_cnt[r] != '0)) ? r_cnt[r] - LAT_W'(1)
                                                            : r_cnt[r];
         end
         w_pop = w_pop + 6'(w_busy_nxt[r]);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   // NOTE: the countdown array is reset explicitly; a pending entry must not
   // survive reset, and the array is small flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy    <= '0;
         r_pending <= '0;
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         r_busy    <= w_busy_nxt;
         r_pending <= w_pop;
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= w_cnt_nxt[r];
         end
      end
   end

   assign stall         = w_stall;
   assign busy_mask     = r_busy;
   assign pending_count = r_pending;

`ifdef RISCV_SCOREBOARD_STATS_EN
   logic [31:0] r_stall_cycles;

   // Free-running stall counter; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
      end else if (w_stall) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign raw_stall    = w_stall && (w_raw1 || w_raw2);
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_riscv_hazard_scoreboard
//
// Directed bench for riscv_hazard_scoreboard: a vector table of
// {inputs, expected stall / busy_mask / pending_count}, followed by
// hand-written sequences for WAW, same-cycle accept+commit, pending count
// accumulation and reset mid-countdown. Outputs are sampled 2 time units after
// the rising edge, i.e. they show the state built by all previous edges.
// Build macro RISCV_SCOREBOARD_STATS_EN also checks the statistics ports.
// -----------------------------------------------------------------------------
module tb_riscv_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_reg_write;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_lat;
   logic [4:0]  id_rs1_addr;
   logic        id_rs1_used;
   logic [4:0]  id_rs2_addr;
   logic        id_rs2_used;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        stall;
   logic [31:0] busy_mask;
   logic [5:0]  pending_count;
`ifdef RISCV_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
   logic        raw_stall;
`endif

   always #5 clk = ~clk;

   riscv_hazard_scoreboard #(.LAT_W(3), .NUM_REGS(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .issue_valid     (issue_valid),
      .issue_reg_write (issue_reg_write),
      .issue_rd        (issue_rd),
      .issue_lat       (issue_lat),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs1_used     (id_rs1_used),
      .id_rs2_addr     (id_rs2_addr),
      .id_rs2_used     (id_rs2_used),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .stall           (stall),
      .busy_mask       (busy_mask),
      .pending_count   (pending_count)
`ifdef RISCV_SCOREBOARD_STATS_EN
      ,
      .stall_cycles    (stall_cycles),
      .raw_stall       (raw_stall)
`endif
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic        rw;
      logic [4:0]  rd;
      logic [2:0]  lat;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic        wv;
      logic [4:0]  wrd;
      logic        chk;
      logic        exp_stall;
      logic [31:0] exp_mask;
      logic [5:0]  exp_pend;
   } vec_t;

   vec_t vecs[$];
   int   n_vec     = 0;
   int   n_miscmp  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic rw, input logic [4:0] rd,
                        input logic [2:0] lat, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic wv,
                        input logic [4:0] wrd);
      issue_valid     = iv;
      issue_reg_write = rw;
      issue_rd        = rd;
      issue_lat       = lat;
      id_rs1_addr     = rs1;
      id_rs1_used     = u1;
      id_rs2_addr     = rs2;
      id_rs2_used     = u2;
      wb_valid        = wv;
      wb_rd           = wrd;
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic iv, input logic rw,
                               input logic [4:0] rd, input logic [2:0] lat,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic wv, input logic [4:0] wrd,
                               input logic chk, input logic es,
                               input logic [31:0] em, input logic [5:0] ep);
      vec_t v;
      v.rst = r;   v.iv = iv;   v.rw = rw;   v.rd = rd;   v.lat = lat;
      v.rs1 = rs1; v.u1 = u1;   v.rs2 = rs2; v.u2 = u2;
      v.wv = wv;   v.wrd = wrd; v.chk = chk;
      v.exp_stall = es; v.exp_mask = em; v.exp_pend = ep;
      return v;
   endfunction

   initial begin
      int n;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      //             rst iv rw rd lat rs1 u1 rs2 u2 wv wrd chk  st  mask          pend
      // Reset held 2 cycles while issuing rd=5 (state unknown in the first cycle)
      vecs.push_back(mk(1, 1, 1, 5, 1,  0, 0,  0, 0, 0, 0,  0,  0, 32'h0,        0));
      vecs.push_back(mk(1, 1, 1, 5, 1,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      // ALU rd=3 lat=1: dependent stalls while cnt=1, then forwards
      vecs.push_back(mk(0, 1, 1, 3, 1,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  3, 1,  0, 0, 0, 0,  1,  1, 32'h8,        1));
      vecs.push_back(mk(0, 1, 0, 0, 0,  3, 1,  0, 0, 0, 0,  1,  0, 32'h8,        1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 3,  1,  0, 32'h8,        1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      // Load rd=7 lat=2: unused rs2 never stalls; used rs2 stalls at cnt=1
      vecs.push_back(mk(0, 1, 1, 7, 2,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,  7, 0, 0, 0,  1,  0, 32'h80,       1));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,  7, 1, 0, 0,  1,  1, 32'h80,       1));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,  7, 1, 0, 0,  1,  0, 32'h80,       1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 7,  1,  0, 32'h80,       1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      // Long latency rd=9 lat=5: dependent stalls for cnt=5..1
      vecs.push_back(mk(0, 1, 1, 9, 5,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 32'h200,      1));
      vecs.push_back(mk(0, 1, 0, 0, 0,  9, 1,  0, 0, 0, 0,  1,  0, 32'h200,      1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 9,  1,  0, 32'h200,      1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      // lat=0 behaves as lat=1
      vecs.push_back(mk(0, 1, 1,10, 0,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 10, 1,  0, 0, 0, 0,  1,  1, 32'h400,      1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 10, 1,  0, 0, 0, 0,  1,  0, 32'h400,      1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1,10,  1,  0, 32'h400,      1));
      // wb_rd=0 ignored; rd=0 / rs=0 never tracked; wb of an idle register harmless
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 0,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 1, 1, 0, 3,  0, 1,  0, 1, 1,20,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1,  0, 1, 0, 0,  1,  0, 32'h0,        0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0, 32'h0,        0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         drive(vecs[i].iv, vecs[i].rw, vecs[i].rd, vecs[i].lat, vecs[i].rs1, vecs[i].u1,
               vecs[i].rs2, vecs[i].u2, vecs[i].wv, vecs[i].wrd);
         if (vecs[i].chk) begin
            check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d busy_mask", i), busy_mask, vecs[i].exp_mask);
            check($sformatf("vec%0d pending_count", i), 32'(pending_count),
                  32'(vecs[i].exp_pend));
`ifdef RISCV_SCOREBOARD_STATS_EN
            check($sformatf("vec%0d raw_stall", i), 32'(raw_stall), 32'(vecs[i].exp_stall));
`endif
         end
         tick();
      end

`ifdef RISCV_SCOREBOARD_STATS_EN
      // Stalled table cycles: 1 (ALU) + 1 (load) + 5 (long) + 1 (lat=0)
      check("stall_cycles after table", stall_cycles, 32'd8);
`endif

      // WAW: rd=4 lat=6, two idle cycles, then rd=4 lat=1 waits for cnt 4,3,2,1
      drive(1, 1, 4, 6, 0, 0, 0, 0, 0, 0);
      check("waw first issue stall", 32'(stall), 32'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("waw busy_mask", busy_mask, 32'h10);
      tick();
      tick();
      drive(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
`ifdef RISCV_SCOREBOARD_STATS_EN
      check("waw raw_stall", 32'(raw_stall), 32'd0);
`endif
      n = 0;
      while (stall && n < 20) begin
         n++;
         tick();
      end
      check("waw stall length", 32'(n), 32'd4);
      tick();
      // cnt[4] reloaded to 1: one dependent stall cycle, then clear
      drive(1, 0, 0, 0, 4, 1, 0, 0, 0, 0);
      check("waw reload stall", 32'(stall), 32'd1);
      tick();
      check("waw reload drained", 32'(stall), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("waw retired mask", busy_mask, 32'h0);

      // Same-cycle accept of rd=6 (lat=3) and commit of the older rd=6
      drive(1, 1, 6, 2, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 6, 3, 0, 0, 0, 0, 1, 6);
      check("simul accept stall", 32'(stall), 32'd0);
      tick();
      drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
      check("simul busy_mask", busy_mask, 32'h40);
      n = 0;
      while (stall && n < 20) begin
         n++;
         tick();
      end
      check("simul reload stall length", 32'(n), 32'd3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
      tick();

      // Pending count accumulation across back-to-back issues
      drive(1, 1, 11, 1, 0, 0, 0, 0, 0, 0);
      check("pend before 11", 32'(pending_count), 32'd0);
      tick();
      drive(1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
      check("pend after 11", 32'(pending_count), 32'd1);
      tick();
      drive(1, 1, 13, 1, 0, 0, 0, 0, 0, 0);
      check("pend after 12", 32'(pending_count), 32'd2);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
      check("pend after 13", 32'(pending_count), 32'd3);
      check("mask 11-13", busy_mask, 32'h3800);
      tick();
      drive(1, 1, 14, 7, 0, 0, 0, 0, 0, 0);
      check("pend after wb 12", 32'(pending_count), 32'd2);
      check("mask after wb 12", busy_mask, 32'h2800);
      tick();

      // Reset in the middle of a lat=7 countdown discards everything
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("pre-reset mask", busy_mask, 32'h6800);
      tick();
      rst = 1'b0;
      drive(1, 0, 0, 0, 14, 1, 13, 1, 0, 0);
      check("post-reset stall", 32'(stall), 32'd0);
      check("post-reset mask", busy_mask, 32'h0);
      check("post-reset pend", 32'(pending_count), 32'd0);
`ifdef RISCV_SCOREBOARD_STATS_EN
      check("post-reset stall_cycles", stall_cycles, 32'd0);
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
